// File: rtl/ysyx_22050078_pipe_ex_ls.sv
// EX -> LS pipeline register with a two-entry skid buffer.
// Keeps o_exu_ready registered and counts LS back-pressure cycles.
module ysyx_22050078_pipe_ex_ls #(
    parameter int CPU_WIDTH = 64,
    parameter int REG_ADDRW = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_exu_valid,
    output logic                 o_exu_ready,
    input  logic [CPU_WIDTH-1:0] i_exu_result,
    input  logic [CPU_WIDTH-1:0] i_exu_rs2_data,
    input  logic [REG_ADDRW-1:0] i_exu_rd_addr,
    input  logic                 i_exu_rdwen,
    input  logic                 i_exu_lden,
    input  logic                 i_exu_sten,
    input  logic [2:0]           i_exu_func3,
    input  logic [CPU_WIDTH-1:0] i_exu_pc,
    input  logic [CPU_WIDTH-1:0] s_exu_diffpc,
    output logic                 o_lsu_valid,
    input  logic                 i_lsu_ready,
    output logic [CPU_WIDTH-1:0] o_lsu_result,
    output logic [CPU_WIDTH-1:0] o_lsu_rs2_data,
    output logic [REG_ADDRW-1:0] o_lsu_rd_addr,
    output logic                 o_lsu_rdwen,
    output logic                 o_lsu_lden,
    output logic                 o_lsu_sten,
    output logic [2:0]           o_lsu_func3,
    output logic [CPU_WIDTH-1:0] o_lsu_pc,
    output logic [CPU_WIDTH-1:0] s_lsu_diffpc,
    output logic [31:0]          o_stall_cnt
);

    typedef struct packed {
        logic [CPU_WIDTH-1:0] result;
        logic [CPU_WIDTH-1:0] rs2_data;
        logic [REG_ADDRW-1:0] rd_addr;
        logic                 rdwen;
        logic                 lden;
        logic                 sten;
        logic [2:0]           func3;
        logic [CPU_WIDTH-1:0] pc;
        logic [CPU_WIDTH-1:0] diffpc;
    } pl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    pl_t         main_q, main_d;
    pl_t         skid_q, skid_d;
    logic        main_vld_q, main_vld_d;
    logic        skid_vld_q, skid_vld_d;
    logic        ready_q, ready_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    pl_t  in_pl;
    logic in_fire;
    logic out_fire;

    assign in_pl = '{
        result:   i_exu_result,
        rs2_data: i_exu_rs2_data,
        rd_addr:  i_exu_rd_addr,
        rdwen:    i_exu_rdwen,
        lden:     i_exu_lden,
        sten:     i_exu_sten,
        func3:    i_exu_func3,
        pc:       i_exu_pc,
        diffpc:   s_exu_diffpc
    };

    assign in_fire  = i_exu_valid & ready_q;
    assign out_fire = main_vld_q & i_lsu_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_pl;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_pl;
                    end else if (in_fire) begin
                        skid_d  = in_pl;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        main_vld_d = (state_d != EMPTY);
        skid_vld_d = (state_d == FULL);
        ready_d    = (state_d != FULL);
    end

    // Saturating count of cycles the LSU holds a valid payload back
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_vld_q && !i_lsu_ready && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            main_vld_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            ready_q     <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            main_vld_q  <= main_vld_d;
            skid_vld_q  <= skid_vld_d;
            ready_q     <= ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    logic unused_skid_vld;
    assign unused_skid_vld = skid_vld_q;

    assign o_exu_ready    = ready_q;
    assign o_lsu_valid    = main_vld_q;
    assign o_lsu_result   = main_q.result;
    assign o_lsu_rs2_data = main_q.rs2_data;
    assign o_lsu_rd_addr  = main_q.rd_addr;
    assign o_lsu_rdwen    = main_q.rdwen & main_vld_q;
    assign o_lsu_lden     = main_q.lden & main_vld_q;
    assign o_lsu_sten     = main_q.sten & main_vld_q;
    assign o_lsu_func3    = main_q.func3;
    assign o_lsu_pc       = main_q.pc;
    // Bubbles carry diffpc = 1 so difftest can skip them
    assign s_lsu_diffpc   = main_vld_q ? main_q.diffpc : CPU_WIDTH'(1);
    assign o_stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_22050078_pipe_ex_ls.sv
// Bench for the EX -> LS skid register.
// Reference model: a 2-deep FIFO queue plus a saturating counter.
module tb_ysyx_22050078_pipe_ex_ls;

    typedef struct packed {
        logic [63:0] result;
        logic [63:0] rs2;
        logic [4:0]  rd;
        logic        rdwen;
        logic        lden;
        logic        sten;
        logic [2:0]  func3;
        logic [63:0] pc;
        logic [63:0] diffpc;
    } pl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fl;
    logic        in_v;
    logic        lrdy;
    pl_t         in_p;
    pl_t         got;
    logic        o_exu_ready;
    logic        o_lsu_valid;
    logic [63:0] o_result, o_rs2, o_pc, o_diffpc;
    logic [4:0]  o_rd;
    logic        o_rdwen, o_lden, o_sten;
    logic [2:0]  o_func3;
    logic [31:0] o_cnt;

    pl_t         mq[$];
    logic [31:0] m_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22050078_pipe_ex_ls dut (
        .i_clk(clk), .i_rst(rst), .i_flush(fl),
        .i_exu_valid(in_v), .o_exu_ready(o_exu_ready),
        .i_exu_result(in_p.result), .i_exu_rs2_data(in_p.rs2),
        .i_exu_rd_addr(in_p.rd), .i_exu_rdwen(in_p.rdwen),
        .i_exu_lden(in_p.lden), .i_exu_sten(in_p.sten),
        .i_exu_func3(in_p.func3), .i_exu_pc(in_p.pc),
        .s_exu_diffpc(in_p.diffpc),
        .o_lsu_valid(o_lsu_valid), .i_lsu_ready(lrdy),
        .o_lsu_result(o_result), .o_lsu_rs2_data(o_rs2),
        .o_lsu_rd_addr(o_rd), .o_lsu_rdwen(o_rdwen),
        .o_lsu_lden(o_lden), .o_lsu_sten(o_sten),
        .o_lsu_func3(o_func3), .o_lsu_pc(o_pc),
        .s_lsu_diffpc(o_diffpc), .o_stall_cnt(o_cnt)
    );

    assign got = {o_result, o_rs2, o_rd, o_rdwen, o_lden, o_sten,
                  o_func3, o_pc, o_diffpc};

    function automatic pl_t rand_pl();
        pl_t p;
        p.result = {$urandom, $urandom};
        p.rs2    = {$urandom, $urandom};
        p.rd     = 5'($urandom);
        p.rdwen  = 1'($urandom);
        p.lden   = 1'($urandom);
        p.sten   = 1'($urandom);
        p.func3  = 3'($urandom);
        p.pc     = {$urandom, $urandom};
        p.diffpc = {$urandom, $urandom};
        return p;
    endfunction

    // One clock: DUT edge plus the model's FIFO/counter update
    task automatic tick();
        bit inf, outf, stall;
        inf   = in_v && (mq.size() < 2);
        outf  = (mq.size() > 0) && lrdy;
        stall = (mq.size() > 0) && !lrdy;
        @(posedge clk);
        if (stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (fl) begin
            mq.delete();
        end else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(in_p);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        in_p = rand_pl(); in_v = 1; lrdy = 0;
        tick();
        in_v = 0;
        tick(); tick();
        n_cmp++;
        if (o_cnt !== m_cnt) begin
            n_bad++; $display("FAIL pre_reset_cnt got %0d want %0d", o_cnt, m_cnt);
        end
        #2 rst = 1;
        #1;
        mq.delete(); m_cnt = 0;
        n_cmp++;
        if (o_lsu_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_valid got %b want 0", o_lsu_valid);
        end
        n_cmp++;
        if (o_exu_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_ready got %b want 1", o_exu_ready);
        end
        n_cmp++;
        if (o_diffpc !== 64'd1) begin
            n_bad++; $display("FAIL rst_diffpc got %h want 1", o_diffpc);
        end
        n_cmp++;
        if (o_cnt !== 32'd0) begin
            n_bad++; $display("FAIL rst_cnt got %0d want 0", o_cnt);
        end
        n_cmp++;
        if ({o_rdwen, o_lden, o_sten} !== 3'b000) begin
            n_bad++; $display("FAIL rst_en got %b want 000", {o_rdwen, o_lden, o_sten});
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_stream();
        logic [63:0] vals [3];
        vals[0] = 64'h10; vals[1] = 64'h20; vals[2] = 64'h30;
        lrdy = 1;
        for (int i = 0; i < 3; i++) begin
            in_p = rand_pl(); in_p.result = vals[i]; in_v = 1;
            tick();
            n_cmp++;
            if (o_lsu_valid !== 1'b1 || o_result !== vals[i]) begin
                n_bad++;
                $display("FAIL stream_%0d got v=%b r=%h want v=1 r=%h",
                         i, o_lsu_valid, o_result, vals[i]);
            end
            n_cmp++;
            if (o_exu_ready !== 1'b1 || o_cnt !== 32'd0) begin
                n_bad++;
                $display("FAIL stream_rdy_%0d got rdy=%b cnt=%0d want 1/0",
                         i, o_exu_ready, o_cnt);
            end
        end
        in_v = 0;
        tick();
        n_cmp++;
        if (o_lsu_valid !== 1'b0) begin
            n_bad++; $display("FAIL stream_drain got %b want 0", o_lsu_valid);
        end
    endtask

    task automatic test_skid_fill();
        pl_t a, b;
        logic [31:0] c0;
        c0 = o_cnt;
        a = rand_pl(); a.result = 64'h100; a.rd = 5'd5; a.rdwen = 1;
        b = rand_pl(); b.result = 64'h200;
        lrdy = 0;
        in_p = a; in_v = 1; tick();
        in_p = b; tick();
        in_v = 0; in_p = rand_pl();
        n_cmp++;
        if (o_exu_ready !== 1'b0) begin
            n_bad++; $display("FAIL skid_ready got %b want 0", o_exu_ready);
        end
        n_cmp++;
        if (o_lsu_valid !== 1'b1 || got !== a) begin
            n_bad++; $display("FAIL skid_hold_a got %h want %h", got, a);
        end
        lrdy = 1; tick();
        n_cmp++;
        if (o_lsu_valid !== 1'b1 || got !== b) begin
            n_bad++; $display("FAIL skid_b got %h want %h", got, b);
        end
        n_cmp++;
        if (o_exu_ready !== 1'b1) begin
            n_bad++; $display("FAIL skid_ready_back got %b want 1", o_exu_ready);
        end
        tick();
        n_cmp++;
        if (o_lsu_valid !== 1'b0) begin
            n_bad++; $display("FAIL skid_empty got %b want 0", o_lsu_valid);
        end
        n_cmp++;
        if (o_cnt !== c0 + 32'd1 || o_cnt !== m_cnt) begin
            n_bad++; $display("FAIL skid_cnt got %0d want %0d", o_cnt, c0 + 32'd1);
        end
    endtask

    task automatic test_flush_full();
        pl_t c;
        lrdy = 0; in_v = 1;
        in_p = rand_pl(); tick();
        in_p = rand_pl(); tick();
        n_cmp++;
        if (o_exu_ready !== 1'b0) begin
            n_bad++; $display("FAIL flush_pre_full got rdy=%b want 0", o_exu_ready);
        end
        c = rand_pl(); c.sten = 1;
        in_p = c; fl = 1; tick();
        fl = 0; in_v = 0; lrdy = 1;
        n_cmp++;
        if (o_lsu_valid !== 1'b0 || o_sten !== 1'b0 || o_diffpc !== 64'd1) begin
            n_bad++;
            $display("FAIL flush_empty got v=%b st=%b dpc=%h want 0/0/1",
                     o_lsu_valid, o_sten, o_diffpc);
        end
        n_cmp++;
        if (o_exu_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush_ready got %b want 1", o_exu_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (o_lsu_valid !== 1'b0) begin
                n_bad++; $display("FAIL flush_ghost_%0d got v=%b want 0", i, o_lsu_valid);
            end
        end
    endtask

    task automatic test_store();
        pl_t s;
        s = rand_pl();
        s.sten = 1; s.lden = 0; s.func3 = 3'b011;
        s.rs2 = 64'hDEADBEEF; s.pc = 64'h8000_0004;
        lrdy = 1; in_p = s; in_v = 1; tick();
        in_v = 0;
        n_cmp++;
        if (o_lsu_valid !== 1'b1 || got !== s) begin
            n_bad++; $display("FAIL store_pass got %h want %h", got, s);
        end
        tick();
    endtask

    task automatic test_saturate();
        lrdy = 0; in_p = rand_pl(); in_v = 1; tick();
        in_v = 0;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (o_cnt !== 32'hFFFF_FFFF || o_cnt !== m_cnt) begin
                n_bad++; $display("FAIL sat_%0d got %h want ffffffff", i, o_cnt);
            end
        end
        lrdy = 1; tick();
        n_cmp++;
        if (o_cnt !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL sat_hold got %h want ffffffff", o_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_p = rand_pl();
            in_v = 1'($urandom);
            lrdy = ($urandom_range(3) != 0);
            fl   = ($urandom_range(15) == 0);
            tick();
            fl = 0;
            n_cmp++;
            if (o_lsu_valid !== (mq.size() > 0) ||
                o_exu_ready !== (mq.size() < 2) || o_cnt !== m_cnt) begin
                n_bad++;
                $display("FAIL rand_ctl_%0d got v=%b r=%b c=%0d want v=%b r=%b c=%0d",
                         i, o_lsu_valid, o_exu_ready, o_cnt,
                         mq.size() > 0, mq.size() < 2, m_cnt);
            end
            n_cmp++;
            if (mq.size() > 0) begin
                if (got !== mq[0]) begin
                    n_bad++; $display("FAIL rand_pl_%0d got %h want %h", i, got, mq[0]);
                end
            end else if ({o_rdwen, o_lden, o_sten} !== 3'b000 || o_diffpc !== 64'd1) begin
                n_bad++;
                $display("FAIL rand_bubble_%0d got en=%b dpc=%h want 000/1",
                         i, {o_rdwen, o_lden, o_sten}, o_diffpc);
            end
        end
        in_v = 0;
    endtask

    initial begin
        rst = 1; fl = 0; in_v = 0; lrdy = 0; in_p = '0;
        m_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_skid_fill();
        test_flush_full();
        test_store();
        test_saturate();
        rst = 1; #1;
        mq.delete(); m_cnt = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
